// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for the bus-based datapath.
// Moore FSM: every strobe decodes from the state register alone. The opcode is
// captured in DEC so that later execute states need no live view of ir.
module control_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15  // 1..255 wait cycles before FAULT
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        pc_out_en,
  output logic        mar_in,
  output logic        pc_increment,
  output logic        pc_in,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        z_out,
  output logic        c_out,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        r_in,
  output logic        r_out,
  output logic [4:0]  alu_op,
  output logic        halted,
  output logic        fault,
  output logic [4:0]  state
);

  typedef enum logic [4:0] {
    StIdle  = 5'd0,
    StT0    = 5'd1,
    StT1    = 5'd2,
    StT2    = 5'd3,
    StDec   = 5'd4,
    StR3    = 5'd5,
    StR4    = 5'd6,
    StR5    = 5'd7,
    StI3    = 5'd8,
    StI4    = 5'd9,
    StI5    = 5'd10,
    StA3    = 5'd11,
    StA4    = 5'd12,
    StA5    = 5'd13,
    StA6    = 5'd14,
    StA7    = 5'd15,
    StS6    = 5'd16,
    StS7    = 5'd17,
    StJ3    = 5'd18,
    StHalt  = 5'd19,
    StFault = 5'd20
  } state_e;

  localparam logic [4:0] OpAdd    = 5'b00011;
  localparam logic [4:0] OpSt     = 5'b00010;
  // Count value on the last permitted wait cycle.
  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [4:0] op_q, op_d;
  logic       waiting;
  state_e     wait_exit;

  // Only the opcode field of ir steers the sequencer.
  logic unused_ir;
  assign unused_ir = ^ir[26:0];

  // State, wait counter and latched opcode; clr wins asynchronously.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      wait_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic; the counter resets whenever a wait state is not re-entered.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    op_d      = op_q;
    waiting   = 1'b0;
    wait_exit = StIdle;
    unique case (state_q)
      StIdle:  if (run) state_d = StT0;
      StT0:    state_d = StT1;
      StT1:    begin waiting = 1'b1; wait_exit = StT2; end
      StT2:    state_d = StDec;
      StDec: begin
        op_d = ir[31:27];
        case (ir[31:27])
          5'b00000, 5'b00010:                     state_d = StA3;
          5'b00011, 5'b00100, 5'b00101, 5'b00110: state_d = StR3;
          5'b01100:                               state_d = StI3;
          5'b10100:                               state_d = StJ3;
          5'b11010:                               state_d = StHalt;
          default:                                state_d = StIdle;
        endcase
      end
      StR3:    state_d = StR4;
      StR4:    state_d = StR5;
      StR5:    state_d = StIdle;
      StI3:    state_d = StI4;
      StI4:    state_d = StI5;
      StI5:    state_d = StIdle;
      StA3:    state_d = StA4;
      StA4:    state_d = StA5;
      StA5:    state_d = (op_q == OpSt) ? StS6 : StA6;
      StA6:    begin waiting = 1'b1; wait_exit = StA7; end
      StA7:    state_d = StIdle;
      StS6:    state_d = StS7;
      StS7:    begin waiting = 1'b1; wait_exit = StIdle; end
      StJ3:    state_d = StIdle;
      StHalt:  state_d = StHalt;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
    // Completion beats timeout when mem_ready arrives on the last wait cycle.
    if (waiting) begin
      if (mem_ready) begin
        state_d = wait_exit;
      end else if (wait_q == WaitLast) begin
        state_d = StFault;
      end else begin
        state_d = state_q;
        wait_d  = wait_q + 8'd1;
      end
    end
  end

  // Strobe decode from the registered state only.
  always_comb begin
    pc_out_en = 1'b0; mar_in = 1'b0; pc_increment = 1'b0; pc_in = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mdr_in = 1'b0; mdr_out = 1'b0; ir_in = 1'b0;
    y_in = 1'b0; z_in = 1'b0; z_out = 1'b0; c_out = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0; r_out = 1'b0;
    alu_op = 5'b00000; halted = 1'b0; fault = 1'b0;
    unique case (state_q)
      StT0:    begin pc_out_en = 1'b1; mar_in = 1'b1; pc_increment = 1'b1; end
      StT1:    begin mem_read = 1'b1; mdr_in = 1'b1; end
      StT2:    begin mdr_out = 1'b1; ir_in = 1'b1; end
      StR3, StI3, StA3: begin grb = 1'b1; r_out = 1'b1; y_in = 1'b1; end
      StR4:    begin grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = op_q; end
      StI4, StA4: begin c_out = 1'b1; z_in = 1'b1; alu_op = OpAdd; end
      StR5, StI5: begin z_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
      StA5:    begin z_out = 1'b1; mar_in = 1'b1; end
      StA6:    begin mem_read = 1'b1; mdr_in = 1'b1; end
      StA7:    begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
      StS6:    begin gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1; end
      StS7:    mem_write = 1'b1;
      StJ3:    begin gra = 1'b1; r_out = 1'b1; pc_in = 1'b1; end
      StHalt:  halted = 1'b1;
      StFault: fault = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle control unit for the Phase 2 bus-based datapath.
- Drives the register enables, the PC increment, the IR/MAR/MDR strobes, the Y/Z latches, the memory read/write strobes and the ALU opcode.
- Steps through fetch and execute sequences using IR contents fed back from the datapath.
- Sits beside the datapath top, replacing the per-cycle testbench stimulus of Phase 2.

Parameters:
- MEM_TIMEOUT, 15, maximum cycles to wait for mem_ready before entering FAULT (1..255).

Ports:
- clk  in  1  system clock, rising-edge
- clr  in  1  reset, asynchronous, active-high
- run  in  1  level; fetch only proceeds while high
- ir  in  32  current IR contents (opcode ir[31:27])
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_out_en, mar_in, pc_increment, pc_in  out  1  PC/MAR strobes
- mem_read, mem_write, mdr_in, mdr_out, ir_in  out  1  memory-path strobes
- y_in, z_in, z_out, c_out  out  1  ALU-path strobes
- gra, grb, grc, r_in, r_out  out  1  register-select and register-file strobes
- alu_op  out  5  ALU operation code
- halted  out  1  high in HALT
- fault  out  1  high in FAULT
- state  out  5  current state encoding, debug only

Behaviour:
- Moore machine: all strobes decode from the state register only, never from inputs. Exception: the state transitions themselves sample run, ir and mem_ready.
- clr asserted (any time, including mid-instruction or mid-wait) -> state = IDLE and wait counter = 0 immediately. All strobes are 0, alu_op = 0, halted = 0, fault = 0.
- IDLE: if run = 1 go to T0, else stay in IDLE.
- T0: pc_out_en, mar_in, pc_increment. Go to T1.
- T1: mem_read, mdr_in. Stay while mem_ready = 0; go to T2 on mem_ready = 1.
- T2: mdr_out, ir_in. Go to DEC.
- DEC: no strobes; branch on opcode:
  - 00000 ld and 00010 st -> A3
  - 00011 add, 00100 sub, 00101 and, 00110 or -> R3
  - 01100 addi -> I3
  - 10100 jr -> J3
  - 11010 halt -> HALT
  - any other opcode (11000 nop, undefined) -> IDLE
- R3: grb, r_out, y_in. R4: grc, r_out, z_in, alu_op = opcode. R5: z_out, gra, r_in. Then IDLE.
- I3: grb, r_out, y_in. I4: c_out, z_in, alu_op = 00011 (add). I5: z_out, gra, r_in. Then IDLE.
- A3: grb, r_out, y_in. A4: c_out, z_in, alu_op = 00011. A5: z_out, mar_in.
  - ld: A6 mem_read, mdr_in, waits on mem_ready; A7 mdr_out, gra, r_in.
  - st: S6 gra, r_out, mdr_in; S7 mem_write, waits on mem_ready.
  - Then IDLE.
- J3: gra, r_out, pc_in. Then IDLE.
- HALT: halted = 1. Leaves only on clr; run is ignored.
- alu_op = 0 in all states not listed above.
- Memory wait (T1, A6, S7):
  - Counter is cleared on entry to the wait state and increments each cycle mem_ready = 0.
  - If it reaches MEM_TIMEOUT with mem_ready still 0 -> FAULT.
  - mem_ready = 1 on the same cycle the count hits MEM_TIMEOUT -> completion wins.
  - mem_read/mem_write stay asserted for every cycle of the wait.
- FAULT: fault = 1, all other strobes 0. Leaves only on clr.
- Minimum latency (mem_ready already high on the first wait cycle):
  - fetch = 4 cycles (T0, T1, T2, DEC)
  - add = 7, addi = 7, ld = 9, st = 9, jr = 5, nop = 4
  - plus one IDLE cycle between instructions
- run dropping mid-instruction does not stop execution; it is sampled only in IDLE.
- pc_increment and pc_in are never asserted in the same state.

Test Plan:
- Reset/async: clr pulsed between clock edges during A6 of a ld -> state = 0 (IDLE) and all strobes 0 before the next edge; after release with run = 1, T0 follows one cycle later.
- add: ir = 0x18000000 | (1<<23)|(2<<19)|(3<<15), mem_ready tied 1 -> exact strobe sequence T0..R5 over 7 cycles; alu_op = 00011 only in R4; r_in with gra only in R5.
- ld with memory wait: ir opcode 00000, mem_ready held low 3 cycles in A6 -> A6 lasts 4 cycles with mem_read high throughout, then A7 asserts mdr_out, gra, r_in.
- Timeout: mem_ready stuck 0 in T1, MEM_TIMEOUT = 4 -> FAULT after 4 wait cycles, fault = 1 held; run toggling has no effect until clr. Separately, mem_ready = 1 exactly on the 4th wait cycle -> T2 reached, no fault.
- jr/halt/unknown: opcode 10100 -> pc_in with gra, r_out in J3; opcode 11010 -> halted = 1 held for 20 cycles with run = 1; opcode 11111 -> returns to IDLE after DEC with no register strobes.
- run gating: run = 0 from reset -> state stays IDLE and pc_increment never pulses; run raised -> T0 on the next edge.
